// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder and the downstream sequence
// detector: state encodings and the default word width.
package serial_word_feeder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_hold_buffer.sv
// One-entry holding register with full flag.
//   i_Clk    in   clock, rising edge
//   Reset_n  in   synchronous reset, active low; clears data and full flag
//   wr_en    in   write wr_data and set full
//   wr_data  in   word to hold
//   rd_en    in   consume the held word (clears full)
//   full     out  a word is held
//   rd_data  out  held word
module serial_hold_buffer #(
   parameter int WIDTH = serial_word_feeder_pkg::DEFAULT_WIDTH
) (
   input  logic             i_Clk,
   input  logic             Reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic             full,
   output logic [WIDTH-1:0] rd_data
);

   always_ff @(posedge i_Clk) begin
      if (!Reset_n) begin
         full    <= 1'b0;
         rd_data <= '0;
      end else if (wr_en) begin
         full    <= 1'b1;
         rd_data <= wr_data;
      end else if (rd_en) begin
         full    <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_word_feeder.sv
// Serialises parallel words (valid/ready) one bit per clock onto o_Sequence.
// A one-word hold buffer keeps back-to-back words gap-free.
//   i_Clk       in   clock, rising edge
//   Reset_n     in   synchronous reset, active low
//   i_Data      in   parallel word
//   i_Valid     in   i_Data valid, held stable until accepted
//   o_Ready     out  feeder can accept (transfer = i_Valid & o_Ready)
//   o_Sequence  out  serial bit, IDLE_BIT when not shifting
//   o_Bit_Valid out  o_Sequence carries a word bit
//   o_Last      out  current bit is the last of its word
//   o_Busy      out  word shifting or word held
module serial_word_feeder
   import serial_word_feeder_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             i_Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] i_Data,
   input  logic             i_Valid,
   output logic             o_Ready,
   output logic             o_Sequence,
   output logic             o_Bit_Valid,
   output logic             o_Last,
   output logic             o_Busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;
   logic             accept;
   logic             at_last;
   logic             hold_wr;
   logic             hold_rd;
   logic             out_bit;

   assign o_Ready = Reset_n & ~hold_full;
   assign accept  = i_Valid & o_Ready;
   assign at_last = (state == SHIFT) && (cnt == LAST_CNT);

   // Hold is only written mid-word; at the boundary an empty hold is bypassed.
   assign hold_wr = accept && (state == SHIFT) && (cnt != LAST_CNT);
   assign hold_rd = at_last && hold_full;

   serial_hold_buffer #(.WIDTH(WIDTH)) u_hold (
      .i_Clk   (i_Clk),
      .Reset_n (Reset_n),
      .wr_en   (hold_wr),
      .wr_data (i_Data),
      .rd_en   (hold_rd),
      .full    (hold_full),
      .rd_data (hold_data)
   );

   always_ff @(posedge i_Clk) begin
      if (!Reset_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sr    <= i_Data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (hold_full) begin
                     sr <= hold_data;
                  end else if (accept) begin
                     sr <= i_Data;
                  end else begin
                     sr    <= '0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  if (MSB_FIRST != 0) sr <= sr << 1;
                  else                sr <= sr >> 1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_bit = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];

   always_comb begin
      o_Sequence  = IDLE_BIT;
      o_Bit_Valid = 1'b0;
      o_Last      = 1'b0;
      if (state == SHIFT) begin
         o_Sequence  = out_bit;
         o_Bit_Valid = 1'b1;
         o_Last      = at_last;
      end
   end

   assign o_Busy = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
module tb_serial_word_feeder;

   logic       i_Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] i_Data;
   logic       i_Valid;

   logic m_ready, m_seq, m_bv, m_last, m_busy;
   logic l_ready, l_seq, l_bv, l_last, l_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // expected {bit, last} per DUT
   logic [1:0] msb_q[$];
   logic [1:0] lsb_q[$];
   int run_len  = 0;
   int last_run = 0;

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_msb;   // emitted bits, bit 7 first
      logic [7:0] exp_lsb;
   } vec_t;

   vec_t vecs[5];

   always #5 i_Clk = ~i_Clk;

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_msb (
      .i_Clk(i_Clk), .Reset_n(Reset_n), .i_Data(i_Data), .i_Valid(i_Valid),
      .o_Ready(m_ready), .o_Sequence(m_seq), .o_Bit_Valid(m_bv),
      .o_Last(m_last), .o_Busy(m_busy));

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
      .i_Clk(i_Clk), .Reset_n(Reset_n), .i_Data(i_Data), .i_Valid(i_Valid),
      .o_Ready(l_ready), .o_Sequence(l_seq), .o_Bit_Valid(l_bv),
      .o_Last(l_last), .o_Busy(l_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop and compare every valid bit from both DUTs.
   always @(negedge i_Clk) begin
      logic [1:0] e;
      if (Reset_n === 1'b1) begin
         if (m_bv) begin
            if (msb_q.size() == 0) check("msb_unexpected_bit", 1, 0);
            else begin
               e = msb_q.pop_front();
               check("msb_bit", {31'd0, m_seq}, {31'd0, e[1]});
               check("msb_last", {31'd0, m_last}, {31'd0, e[0]});
            end
            run_len++;
         end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
         end
         if (l_bv) begin
            if (lsb_q.size() == 0) check("lsb_unexpected_bit", 1, 0);
            else begin
               e = lsb_q.pop_front();
               check("lsb_bit", {31'd0, l_seq}, {31'd0, e[1]});
               check("lsb_last", {31'd0, l_last}, {31'd0, e[0]});
            end
         end
      end else begin
         run_len = 0;
      end
   end

   // Call between clock edges. Returns #1 after the accepting edge.
   task automatic send_word(input int idx);
      logic rdy;
      logic accepted;
      accepted = 1'b0;
      i_Valid  = 1'b1;
      i_Data   = vecs[idx].data;
      for (int k = 0; k < 50; k++) begin
         rdy = m_ready;
         @(posedge i_Clk);
         if (rdy) begin
            accepted = 1'b1;
            for (int b = 0; b < 8; b++) begin
               msb_q.push_back({vecs[idx].exp_msb[7-b], (b == 7) ? 1'b1 : 1'b0});
               lsb_q.push_back({vecs[idx].exp_lsb[7-b], (b == 7) ? 1'b1 : 1'b0});
            end
            break;
         end
      end
      #1;
      i_Valid = 1'b0;
      if (!accepted) check("accept_timeout", 0, 1);
   endtask

   task automatic drain(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge i_Clk);
         #1;
         if (msb_q.size() == 0 && lsb_q.size() == 0 && !m_busy && !l_busy) begin
            done = 1'b1;
            break;
         end
      end
      check({name, "_drain"}, {31'd0, done}, 32'd1);
      check({name, "_idle_bv"}, {30'd0, m_bv, l_bv}, 32'd0);
      check({name, "_idle_seq"}, {30'd0, m_seq, l_seq}, 32'd0);
      check({name, "_idle_ready"}, {30'd0, m_ready, l_ready}, 32'd3);
   endtask

   initial begin
      vecs[0] = '{8'h3B, 8'h3B, 8'hDC};
      vecs[1] = '{8'hE1, 8'hE1, 8'h87};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{8'h0F, 8'h0F, 8'hF0};
      vecs[4] = '{8'h80, 8'h80, 8'h01};

      // Reset with i_Valid asserted: nothing transfers.
      Reset_n = 1'b0;
      i_Valid = 1'b1;
      i_Data  = 8'h3B;
      repeat (2) @(posedge i_Clk);
      @(negedge i_Clk);
      check("rst_ready", {30'd0, m_ready, l_ready}, 32'd0);
      check("rst_seq",   {30'd0, m_seq, l_seq}, 32'd0);
      check("rst_busy",  {30'd0, m_busy, l_busy}, 32'd0);
      check("rst_bv",    {30'd0, m_bv, l_bv}, 32'd0);
      i_Valid = 1'b0;
      Reset_n = 1'b1;
      @(negedge i_Clk);
      check("post_rst_ready", {30'd0, m_ready, l_ready}, 32'd3);
      check("post_rst_busy",  {30'd0, m_busy, l_busy}, 32'd0);
      check("post_rst_last",  {30'd0, m_last, l_last}, 32'd0);

      // Single words from the table.
      for (int v = 0; v < 5; v++) begin
         send_word(v);
         @(negedge i_Clk);
         check("latency_first_bit", {30'd0, m_bv, l_bv}, 32'd3);
         drain("single");
         check("single_run", last_run, 8);
      end

      // Back-to-back: E1 presented during bit 2 of 3B goes into hold.
      send_word(0);
      repeat (3) @(negedge i_Clk);
      send_word(1);
      @(negedge i_Clk);
      check("b2b_ready_low", {30'd0, m_ready, l_ready}, 32'd0);
      check("b2b_busy", {30'd0, m_busy, l_busy}, 32'd3);
      drain("b2b");
      check("b2b_run", last_run, 16);

      // Bypass: E1 presented in the o_Last cycle of 3B with hold empty.
      send_word(0);
      for (int k = 0; k < 20; k++) begin
         @(negedge i_Clk);
         if (m_last) break;
      end
      check("bypass_at_last", {31'd0, m_last}, 32'd1);
      check("bypass_ready", {31'd0, m_ready}, 32'd1);
      send_word(1);
      drain("bypass");
      check("bypass_run", last_run, 16);

      // Mid-word reset: FF shifting, 0F held, reset after bit 3.
      send_word(2);
      @(negedge i_Clk);
      send_word(3);
      repeat (3) @(negedge i_Clk);
      #1;
      Reset_n = 1'b0;
      @(negedge i_Clk);
      msb_q.delete();
      lsb_q.delete();
      check("midrst_bv", {30'd0, m_bv, l_bv}, 32'd0);
      check("midrst_busy", {30'd0, m_busy, l_busy}, 32'd0);
      check("midrst_ready", {30'd0, m_ready, l_ready}, 32'd0);
      #1;
      Reset_n = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (12) begin
            @(negedge i_Clk);
            if (m_bv || l_bv || m_busy || l_busy) seen++;
         end
         check("midrst_no_resume", seen, 0);
      end
      check("midrst_ready_back", {30'd0, m_ready, l_ready}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
